// File: rtl/mem_stage.sv
// MEM stage of the pipeline: EX/MEM register, word-addressed data memory and
// MEM/WB register. Optional load/store statistics counters are built only when
// MEM_STAT_EN is defined; without it the counters and their ports are absent.
module mem_stage #(
  parameter int unsigned DMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] result,
  input  logic [31:0] storeData,
  input  logic [4:0]  rw,
  input  logic        MemWr,
  input  logic        MemtoReg,
  input  logic        RegWr,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] MEMResult,
  output logic [4:0]  mem_rw,
  output logic        mem_RegWr,
  output logic [31:0] WRresult,
  output logic [4:0]  wb_rw,
  output logic        wb_RegWr,
  output logic        misalign
`ifdef MEM_STAT_EN
  ,
  output logic [15:0] ld_count,
  output logic [15:0] st_count
`endif
);

  localparam int unsigned AW = $clog2(DMEM_WORDS);

  // EX/MEM register
  logic [31:0] mem_result_q;
  logic [31:0] mem_sdata_q;
  logic [4:0]  mem_rw_q;
  logic        mem_memwr_q;
  logic        mem_memtoreg_q;
  logic        mem_regwr_q;

  // MEM/WB register
  logic [31:0] wb_result_q;
  logic [4:0]  wb_rw_q;
  logic        wb_regwr_q;

  logic [31:0] dmem [DMEM_WORDS];

  logic [AW-1:0] addr;
  logic          aligned;
  logic [31:0]   rdata;
  logic          mem_we;
  logic [31:0]   wb_data;

  // Address decode, read-before-write data path and write enable
  always_comb begin
    addr    = mem_result_q[AW+1:2];
    aligned = (mem_result_q[1:0] == 2'b00);
    rdata   = dmem[addr];
    // Misaligned stores are dropped; a stall or reset also blocks the write.
    mem_we  = mem_memwr_q & aligned & ~stall & ~rst;
    wb_data = mem_memtoreg_q ? rdata : mem_result_q;
  end

  // EX/MEM capture: reset, then flush (bubble, even under stall), then stall hold
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_result_q   <= '0;
      mem_sdata_q    <= '0;
      mem_rw_q       <= '0;
      mem_memwr_q    <= 1'b0;
      mem_memtoreg_q <= 1'b0;
      mem_regwr_q    <= 1'b0;
    end else if (flush) begin
      mem_result_q   <= result;
      mem_sdata_q    <= storeData;
      mem_rw_q       <= rw;
      mem_memwr_q    <= 1'b0;
      mem_memtoreg_q <= 1'b0;
      mem_regwr_q    <= 1'b0;
    end else if (!stall) begin
      mem_result_q   <= result;
      mem_sdata_q    <= storeData;
      mem_rw_q       <= rw;
      mem_memwr_q    <= MemWr;
      mem_memtoreg_q <= MemtoReg;
      mem_regwr_q    <= RegWr;
    end
  end

  // MEM/WB capture; writes to x0 are squashed here
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_result_q <= '0;
      wb_rw_q     <= '0;
      wb_regwr_q  <= 1'b0;
    end else if (!stall) begin
      wb_result_q <= wb_data;
      wb_rw_q     <= mem_rw_q;
      wb_regwr_q  <= mem_regwr_q & (mem_rw_q != 5'd0);
    end
  end

  // Data memory write port; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      dmem[addr] <= mem_sdata_q;
    end
  end

  // Registered stage outputs
  always_comb begin
    MEMResult = mem_result_q;
    mem_rw    = mem_rw_q;
    mem_RegWr = mem_regwr_q;
    WRresult  = wb_result_q;
    wb_rw     = wb_rw_q;
    wb_RegWr  = wb_regwr_q;
    misalign  = (mem_memwr_q | mem_memtoreg_q) & ~aligned;
  end

`ifdef MEM_STAT_EN
  logic [15:0] ld_cnt_q;
  logic [15:0] st_cnt_q;

  // Saturating counts of accepted (aligned, non-stalled) loads and stores
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_cnt_q <= '0;
      st_cnt_q <= '0;
    end else if (!stall && aligned) begin
      if (mem_memtoreg_q && (ld_cnt_q != 16'hFFFF)) ld_cnt_q <= ld_cnt_q + 16'd1;
      if (mem_memwr_q && (st_cnt_q != 16'hFFFF)) st_cnt_q <= st_cnt_q + 16'd1;
    end
  end

  assign ld_count = ld_cnt_q;
  assign st_count = st_cnt_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: a vector table streamed through the
// pipeline with a two-level scoreboard (MEM then WB), followed by hand-written
// stall, flush, misalign and reset sequences.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] result, storeData;
  logic [4:0]  rw;
  logic        MemWr, MemtoReg, RegWr, stall, flush;
  logic [31:0] MEMResult, WRresult;
  logic [4:0]  mem_rw, wb_rw;
  logic        mem_RegWr, wb_RegWr, misalign;
`ifdef MEM_STAT_EN
  logic [15:0] ld_count, st_count;
`endif

  int checks = 0;
  int errors = 0;

  mem_stage #(.DMEM_WORDS(256)) dut (
    .clk(clk), .rst(rst), .result(result), .storeData(storeData), .rw(rw),
    .MemWr(MemWr), .MemtoReg(MemtoReg), .RegWr(RegWr), .stall(stall), .flush(flush),
    .MEMResult(MEMResult), .mem_rw(mem_rw), .mem_RegWr(mem_RegWr),
    .WRresult(WRresult), .wb_rw(wb_rw), .wb_RegWr(wb_RegWr), .misalign(misalign)
`ifdef MEM_STAT_EN
    , .ld_count(ld_count), .st_count(st_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [31:0] sd;
    logic [4:0]  rw;
    logic        mw, mr, wr;
    logic [31:0] exp_wr;
    logic        exp_wbregwr;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];
  vec_t q_mem[$];
  vec_t q_wb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] r, input logic [31:0] sd, input logic [4:0] d,
                       input logic mw, input logic mr, input logic wr,
                       input logic st, input logic fl);
    result = r; storeData = sd; rw = d; MemWr = mw; MemtoReg = mr; RegWr = wr;
    stall = st; flush = fl;
  endtask

  task automatic nop();
    drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " MEMResult"}, MEMResult, 32'h0);
    chk({nm, " mem_rw"}, {27'd0, mem_rw}, 32'h0);
    chk({nm, " mem_RegWr"}, {31'd0, mem_RegWr}, 32'h0);
    chk({nm, " WRresult"}, WRresult, 32'h0);
    chk({nm, " wb_rw"}, {27'd0, wb_rw}, 32'h0);
    chk({nm, " wb_RegWr"}, {31'd0, wb_RegWr}, 32'h0);
    chk({nm, " misalign"}, {31'd0, misalign}, 32'h0);
  endtask

  function automatic vec_t mk(input logic [31:0] r, input logic [31:0] sd, input logic [4:0] d,
                              input logic mw, input logic mr, input logic wr,
                              input logic [31:0] ewr, input logic ewb, input logic emis);
    vec_t v;
    v.res = r; v.sd = sd; v.rw = d; v.mw = mw; v.mr = mr; v.wr = wr;
    v.exp_wr = ewr; v.exp_wbregwr = ewb; v.exp_mis = emis;
    return v;
  endfunction

  initial begin
    vec_t v;
    int n;

    //              result        storeData     rw  mw mr wr  exp WRresult  wbRW mis
    vecs.push_back(mk(32'h20,     32'h88888888, 0,  1, 0, 0, 32'h20,       0, 0));
    vecs.push_back(mk(32'h30,     32'hCCCCCCCC, 0,  1, 0, 0, 32'h30,       0, 0));
    vecs.push_back(mk(32'h10,     32'hDEADBEEF, 0,  1, 0, 0, 32'h10,       0, 0));
    vecs.push_back(mk(32'h10,     32'h0,        7,  0, 1, 1, 32'hDEADBEEF, 1, 0));
    vecs.push_back(mk(32'h5,      32'h0,        3,  0, 0, 1, 32'h5,        1, 0));
    vecs.push_back(mk(32'h1234,   32'h0,        0,  0, 0, 1, 32'h1234,     0, 0));
    vecs.push_back(mk(32'h14,     32'hCAFEF00D, 0,  1, 0, 0, 32'h14,       0, 0));
    // 0x414 wraps onto word 5, same as 0x14
    vecs.push_back(mk(32'h414,    32'h11111111, 0,  1, 0, 0, 32'h414,      0, 0));
    vecs.push_back(mk(32'h14,     32'h0,        9,  0, 1, 1, 32'h11111111, 1, 0));
    vecs.push_back(mk(32'h16,     32'h0,        10, 0, 1, 1, 32'h11111111, 1, 1));
    // combined store+load reads the old word
    vecs.push_back(mk(32'h14,     32'h22222222, 11, 1, 1, 1, 32'h11111111, 1, 0));
    vecs.push_back(mk(32'h14,     32'h0,        12, 0, 1, 1, 32'h22222222, 1, 0));
    vecs.push_back(mk(32'h22,     32'hBAD0BAD0, 0,  1, 0, 0, 32'h22,       0, 1));
    vecs.push_back(mk(32'h20,     32'h0,        13, 0, 1, 1, 32'h88888888, 1, 0));
    vecs.push_back(mk(32'hFFFFFFFF, 32'h0,      31, 0, 0, 0, 32'hFFFFFFFF, 0, 0));

    // Reset state
    rst = 1'b1;
    nop();
    tick();
    tick();
    chk_zero("reset");
    rst = 1'b0;

    // Table stream through the scoreboard
    n = vecs.size();
    for (int i = 0; i < n + 2; i++) begin
      if (i < n) begin
        v = vecs[i];
        drive(v.res, v.sd, v.rw, v.mw, v.mr, v.wr, 1'b0, 1'b0);
        q_mem.push_back(v);
      end else begin
        nop();
      end
      tick();
      if (q_wb.size() > 0) begin
        v = q_wb.pop_front();
        chk($sformatf("vec wb WRresult rw=%0d", v.rw), WRresult, v.exp_wr);
        chk($sformatf("vec wb_rw rw=%0d", v.rw), {27'd0, wb_rw}, {27'd0, v.rw});
        chk($sformatf("vec wb_RegWr rw=%0d", v.rw), {31'd0, wb_RegWr}, {31'd0, v.exp_wbregwr});
      end
      if (q_mem.size() > 0) begin
        v = q_mem.pop_front();
        chk($sformatf("vec MEMResult rw=%0d", v.rw), MEMResult, v.res);
        chk($sformatf("vec mem_rw rw=%0d", v.rw), {27'd0, mem_rw}, {27'd0, v.rw});
        chk($sformatf("vec mem_RegWr rw=%0d", v.rw), {31'd0, mem_RegWr}, {31'd0, v.wr});
        chk($sformatf("vec misalign rw=%0d", v.rw), {31'd0, misalign}, {31'd0, v.exp_mis});
        q_wb.push_back(v);
      end
    end

    // Stall holds both registers for three cycles
    drive(32'h77, 32'h0, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(32'h99, 32'h0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(32'hAA, 32'h0, 5'd6, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("stall MEMResult", MEMResult, 32'h99);
      chk("stall mem_rw", {27'd0, mem_rw}, 32'd5);
      chk("stall WRresult", WRresult, 32'h77);
      chk("stall wb_rw", {27'd0, wb_rw}, 32'd4);
      chk("stall wb_RegWr", {31'd0, wb_RegWr}, 32'd1);
    end
    nop();
    tick();
    chk("unstall WRresult", WRresult, 32'h99);
    chk("unstall wb_rw", {27'd0, wb_rw}, 32'd5);

    // Flush turns a store into a bubble; word 8 keeps its value
    drive(32'h20, 32'h0BAD0001, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    chk("flush mem_RegWr", {31'd0, mem_RegWr}, 32'd0);
    nop();
    tick();
    chk("flush wb_RegWr", {31'd0, wb_RegWr}, 32'd0);
    drive(32'h20, 32'h0, 5'd6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    nop();
    tick();
    chk("flush word8", WRresult, 32'h88888888);
    chk("flush load wb_rw", {27'd0, wb_rw}, 32'd6);
    chk("flush load wb_RegWr", {31'd0, wb_RegWr}, 32'd1);

    // Stalled store does not write; flush+stall bubbles EX/MEM, MEM/WB holds
    drive(32'h55, 32'h0, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(32'h30, 32'h0BAD0002, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("stall store MEMResult", MEMResult, 32'h30);
    chk("stall store WRresult", WRresult, 32'h55);
    drive(32'h66, 32'h0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    chk("flush+stall mem_RegWr", {31'd0, mem_RegWr}, 32'd0);
    chk("flush+stall WRresult", WRresult, 32'h55);
    chk("flush+stall wb_rw", {27'd0, wb_rw}, 32'd8);
    drive(32'h30, 32'h0, 5'd14, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    nop();
    tick();
    chk("stall store word12", WRresult, 32'hCCCCCCCC);

    // Reset while a store to 0x30 is latched
    drive(32'h30, 32'h0BAD0003, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("pre-reset MEMResult", MEMResult, 32'h30);
    rst = 1'b1;
    tick();
    chk_zero("midreset");
`ifdef MEM_STAT_EN
    chk("reset ld_count", {16'd0, ld_count}, 32'd0);
    chk("reset st_count", {16'd0, st_count}, 32'd0);
`endif
    rst = 1'b0;
    drive(32'h30, 32'h0, 5'd15, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    nop();
    tick();
    chk("reset word12", WRresult, 32'hCCCCCCCC);
    chk("reset load wb_rw", {27'd0, wb_rw}, 32'd15);

`ifdef MEM_STAT_EN
    rst = 1'b1;
    nop();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 65540; k++) begin
      drive(32'h40, k, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    nop();
    tick();
    chk("st_count saturate", {16'd0, st_count}, 32'h0000FFFF);
    chk("ld_count idle", {16'd0, ld_count}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL provide parameter DMEM_WORDS, default 256, meaning data memory depth in 32-bit words (power of two).
REQ-002 SHALL provide ports: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-003 SHALL provide ports: result  in  32  EX ALU result (load/store byte address or ALU value); storeData  in  32  forwarded store data.
REQ-004 SHALL provide ports: rw  in  5  EX destination register; MemWr  in  1  store; MemtoReg  in  1  load; RegWr  in  1  register write enable.
REQ-005 SHALL provide ports: stall  in  1  hold both pipeline registers; flush  in  1  turn captured EX instruction into bubble.
REQ-006 SHALL provide ports: MEMResult  out  32  EX/MEM latched result (ForwardX=2'b10 source); mem_rw  out  5; mem_RegWr  out  1.
REQ-007 SHALL provide ports: WRresult  out  32  MEM/WB write-back data (ForwardX=2'b01 source); wb_rw  out  5; wb_RegWr  out  1; misalign  out  1.
REQ-008 SHALL provide, only when MEM_STAT_EN defined: ld_count  out  16; st_count  out  16.

Function
REQ-009 SHALL capture result, storeData, rw, MemWr, MemtoReg, RegWr into EX/MEM register on each rising edge with stall=0.
REQ-010 SHALL, on flush=1 and stall=0, capture EX/MEM with MemWr=0, MemtoReg=0, RegWr=0 (bubble); data fields don't-care.
REQ-011 SHALL give flush priority over stall: flush=1, stall=1 loads bubble into EX/MEM; MEM/WB still holds.
REQ-012 SHALL, with stall=1 and flush=0, hold EX/MEM and MEM/WB unchanged and perform no memory write.
REQ-013 SHALL word-address data memory with EX/MEM result[log2(DMEM_WORDS)+1:2]; upper address bits ignored (wrap-around).
REQ-014 SHALL read memory combinationally within MEM stage; store written at rising edge ending the MEM cycle.
REQ-015 SHALL write memory only when latched MemWr=1, stall=0, rst=0, result[1:0]=2'b00.
REQ-016 SHALL assert misalign combinationally while latched (MemWr or MemtoReg)=1 and result[1:0]!=0; misaligned store suppressed, misaligned load returns word at truncated address.
REQ-017 SHALL, in the same cycle as a store to address A, return the old word on a load of A (read-before-write); a load in the following cycle sees the new word.
REQ-018 SHALL capture MEM/WB on non-stalled edges: WRresult = MemtoReg ? memory word : MEMResult; wb_rw = mem_rw.
REQ-019 SHALL force wb_RegWr=0 when mem_rw=5'd0; otherwise wb_RegWr = mem_RegWr.
REQ-020 SHALL give total latency: EX signals visible on MEMResult 1 edge later, on WRresult 2 edges later, absent stalls.

Reset
REQ-021 SHALL, on rst=1 at a rising edge, clear every EX/MEM and MEM/WB field to zero; all outputs 0 next cycle (misalign 0).
REQ-022 SHALL give rst priority over stall and flush; a store latched when rst asserts is not written.
REQ-023 SHALL not reset data memory contents.

Configuration
REQ-024 SHALL, with MEM_STAT_EN defined, count accepted loads/stores (aligned, non-stalled, non-bubble) in ld_count/st_count, saturating at 16'hFFFF, cleared by rst.
REQ-025 SHALL, without MEM_STAT_EN, omit ld_count, st_count and their counters entirely; all other behaviour identical.

Verification
REQ-026 SHALL verify store then load: store result=32'h10, storeData=32'hDEADBEEF; next cycle load result=32'h10 -> WRresult=32'hDEADBEEF 2 edges after load issue, wb_rw as given.
REQ-027 SHALL verify forwarding timing: ALU op result=32'h5, rw=3, RegWr=1 -> MEMResult=5, mem_rw=3 after 1 edge; WRresult=5, wb_RegWr=1 after 2 edges.
REQ-028 SHALL verify stall/flush: stall=1 for 3 cycles holds all outputs; flush=1 with store to 32'h20 -> word 8 unchanged, mem_RegWr=0.
REQ-029 SHALL verify misalign: store to 32'h22 -> misalign=1, word 8 unchanged; rw=0 with RegWr=1 -> wb_RegWr=0.
REQ-030 SHALL verify reset mid-operation: rst during latched store to 32'h30 -> word 12 unchanged, all outputs 0; with MEM_STAT_EN, counters 0 and saturate at 16'hFFFF after 65536+ stores.
